// File: rtl/ahb_dmem_slave_if.sv
// ============================================================================
// Module      : ahb_dmem_slave_if
// Description : AHB-Lite bus bundle between the ME2 ldst2_ahb master and the
//               data-memory responder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ahb_dmem_slave_if;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic        HREADY;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADYOUT;
  logic        HRESP;

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HREADY, HWDATA,
    input  HRDATA, HREADYOUT, HRESP
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HREADY, HWDATA,
    output HRDATA, HREADYOUT, HRESP
  );
endinterface

`default_nettype wire

// File: rtl/ahb_dmem_slave.sv
// ============================================================================
// Module      : ahb_dmem_slave
// Description : AHB-Lite data-memory responder. Word-organised SRAM serving
//               byte/half/word loads and stores, fixed wait states, two-cycle
//               ERROR response on misaligned or oversized accesses.
//               Optional macro DMEM_WAIT_LFSR_EN adds 0..3 pseudo-random
//               extra wait cycles per legal access.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ahb_dmem_slave #(
  parameter int ADDR_W      = 12,
  parameter int WAIT_STATES = 0
) (
  input  logic             CLK,
  input  logic             RST,
  ahb_dmem_slave_if.slave  bus
);

  localparam logic [2:0] c_st_idle = 3'd0;
  localparam logic [2:0] c_st_wait = 3'd1;
  localparam logic [2:0] c_st_data = 3'd2;
  localparam logic [2:0] c_st_err1 = 3'd3;
  localparam logic [2:0] c_st_err2 = 3'd4;
  localparam logic [4:0] c_wait    = 5'(WAIT_STATES);

  logic [2:0]        r_state;
  logic [2:0]        w_state_nxt;
  logic [ADDR_W+1:0] r_addr_q;
  logic              r_write_q;
  logic [1:0]        r_size_q;
  logic [4:0]        r_wait_cnt;
  logic [31:0]       r_rdata_q;
  logic [31:0]       r_mem [0:(1<<ADDR_W)-1];

  logic              w_can_accept;
  logic              w_accept;
  logic              w_illegal;
  logic              w_legal_acc;
  logic [1:0]        w_extra;
  logic [4:0]        w_lat;
  logic              w_wr_en;
  logic [3:0]        w_be;
  logic [ADDR_W-1:0] w_wr_idx;
  logic [ADDR_W-1:0] w_rd_idx;
  logic              w_rd_load;
  logic              w_bypass;
  logic [31:0]       w_rd_word;
  logic              w_unused;

  // Region decode belongs to HSEL, so upper address bits are ignored
  assign w_unused = ^{bus.HTRANS[0], bus.HADDR[31:ADDR_W+2]};

  // WAIT and ERR1 drive HREADYOUT low, so no new address phase can complete
  // there; gating keeps a stray HREADY from corrupting an in-flight transfer.
  assign w_can_accept = (r_state == c_st_idle) || (r_state == c_st_data) ||
                        (r_state == c_st_err2);
  assign w_accept     = bus.HSEL & bus.HTRANS[1] & bus.HREADY & w_can_accept;
  assign w_illegal    = (bus.HSIZE > 3'd2) ||
                        ((bus.HSIZE == 3'd1) && bus.HADDR[0]) ||
                        ((bus.HSIZE == 3'd2) && (bus.HADDR[1:0] != 2'b00));
  assign w_legal_acc  = w_accept & ~w_illegal;

`ifdef DMEM_WAIT_LFSR_EN
  logic [15:0] r_lfsr;

  // Fibonacci LFSR (taps 16,14,13,11) stepped once per legal acceptance
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_lfsr <= 16'hACE1;
    end else if (w_legal_acc) begin
      r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
    end
  end

  assign w_extra = r_lfsr[1:0];
`else
  assign w_extra = 2'b00;
`endif

  assign w_lat = c_wait + {3'b000, w_extra};

  // State register
  always_ff @(posedge CLK) begin
    if (RST) r_state <= c_st_idle;
    else     r_state <= w_state_nxt;
  end

  // Next-state decode; IDLE, DATA and ERR2 share the acceptance rules
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_wait: if (r_wait_cnt == 5'd0) w_state_nxt = c_st_data;
      c_st_err1: w_state_nxt = c_st_err2;
      default: begin
        if (!w_accept)            w_state_nxt = c_st_idle;
        else if (w_illegal)       w_state_nxt = c_st_err1;
        else if (w_lat != 5'd0)   w_state_nxt = c_st_wait;
        else                      w_state_nxt = c_st_data;
      end
    endcase
  end

  // Bus outputs; read data only shown in the completing cycle of a load
  always_comb begin
    bus.HREADYOUT = 1'b1;
    bus.HRESP     = 1'b0;
    bus.HRDATA    = 32'h0;
    case (r_state)
      c_st_wait: bus.HREADYOUT = 1'b0;
      c_st_data: if (!r_write_q) bus.HRDATA = r_rdata_q;
      c_st_err1: begin
        bus.HREADYOUT = 1'b0;
        bus.HRESP     = 1'b1;
      end
      c_st_err2: bus.HRESP = 1'b1;
      default: ;
    endcase
  end

  // Address-phase capture; reset drops any pending write
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_addr_q  <= '0;
      r_write_q <= 1'b0;
      r_size_q  <= 2'b00;
    end else if (w_accept) begin
      r_addr_q  <= bus.HADDR[ADDR_W+1:0];
      r_write_q <= bus.HWRITE;
      r_size_q  <= bus.HSIZE[1:0];
    end
  end

  // Wait counter: loads latency-1 on acceptance, counts down through WAIT
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_wait_cnt <= 5'd0;
    end else if (w_legal_acc) begin
      r_wait_cnt <= (w_lat != 5'd0) ? (w_lat - 5'd1) : 5'd0;
    end else if ((r_state == c_st_wait) && (r_wait_cnt != 5'd0)) begin
      r_wait_cnt <= r_wait_cnt - 5'd1;
    end
  end

  // Store lanes; a reset edge suppresses the write so an aborted store is lost
  assign w_wr_en  = (r_state == c_st_data) & r_write_q & ~RST;
  assign w_wr_idx = r_addr_q[ADDR_W+1:2];
  always_comb begin
    case (r_size_q)
      2'd0:    w_be = 4'b0001 << r_addr_q[1:0];
      2'd1:    w_be = 4'b0011 << r_addr_q[1:0];
      default: w_be = 4'b1111;
    endcase
  end

  // Array write at completion; contents survive reset
  always_ff @(posedge CLK) begin
    for (int b = 0; b < 4; b++) begin
      if (w_wr_en && w_be[b]) r_mem[w_wr_idx][8*b +: 8] <= bus.HWDATA[8*b +: 8];
    end
  end

  // Read word selection with same-edge store bypass per enabled lane
  assign w_rd_idx  = w_legal_acc ? bus.HADDR[ADDR_W+1:2] : r_addr_q[ADDR_W+1:2];
  assign w_rd_load = w_legal_acc | (r_state == c_st_wait);
  assign w_bypass  = w_wr_en & (w_rd_idx == w_wr_idx);
  always_comb begin
    w_rd_word = r_mem[w_rd_idx];
    for (int b = 0; b < 4; b++) begin
      if (w_bypass && w_be[b]) w_rd_word[8*b +: 8] = bus.HWDATA[8*b +: 8];
    end
  end

  // Read data register, refreshed on acceptance and every WAIT edge
  always_ff @(posedge CLK) begin
    if (RST)            r_rdata_q <= 32'h0;
    else if (w_rd_load) r_rdata_q <= w_rd_word;
  end

endmodule

`default_nettype wire

// File: tb/tb_ahb_dmem_slave.sv
// ============================================================================
// Module      : tb_ahb_dmem_slave
// Description : Self-checking bench for ahb_dmem_slave: vector table with a
//               response scoreboard on a zero-wait instance, plus hand
//               sequences for bypass, wait states, HREADY blocking and reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ahb_dmem_slave;

  logic clk = 1'b0;
  logic rst0;
  logic rst2;
  always #5 clk = ~clk;

  ahb_dmem_slave_if bus0();
  ahb_dmem_slave_if bus2();

  ahb_dmem_slave #(.ADDR_W(12), .WAIT_STATES(0)) dut0 (.CLK(clk), .RST(rst0), .bus(bus0.slave));
  ahb_dmem_slave #(.ADDR_W(12), .WAIT_STATES(2)) dut2 (.CLK(clk), .RST(rst2), .bus(bus2.slave));

  typedef struct {
    logic        wr;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    logic        wr;
    logic        err;
    logic [31:0] exp;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Compare the data phase of the oldest outstanding transfer on dut0
  task automatic check_resp0();
    exp_t e;
    e = sb.pop_front();
    if (e.err) begin
      chk("err1_hreadyout", 32'(bus0.HREADYOUT), 32'd0);
      chk("err1_hresp",     32'(bus0.HRESP),     32'd1);
      step();
      chk("err2_hreadyout", 32'(bus0.HREADYOUT), 32'd1);
      chk("err2_hresp",     32'(bus0.HRESP),     32'd1);
      step();
      chk("post_err_hresp", 32'(bus0.HRESP),     32'd0);
    end else begin
      chk("ok_hreadyout", 32'(bus0.HREADYOUT), 32'd1);
      chk("ok_hresp",     32'(bus0.HRESP),     32'd0);
      if (!e.wr) chk("load_hrdata", bus0.HRDATA, e.exp);
      step();
    end
  endtask

  task automatic run_vec0(input vec_t v);
    bus0.HSEL   = 1'b1;
    bus0.HTRANS = 2'b10;
    bus0.HWRITE = v.wr;
    bus0.HSIZE  = v.size;
    bus0.HADDR  = v.addr;
    sb.push_back('{v.wr, v.err, v.exp});
    step();
    bus0.HSEL   = 1'b0;
    bus0.HTRANS = 2'b00;
    bus0.HWDATA = v.wdata;
    check_resp0();
  endtask

  // Word transfer on the two-wait-state instance, counting stall cycles
  task automatic xfer2(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp, input int exp_waits);
    int waits;
    waits = 0;
    bus2.HSEL   = 1'b1;
    bus2.HTRANS = 2'b10;
    bus2.HWRITE = wr;
    bus2.HSIZE  = 3'd2;
    bus2.HADDR  = addr;
    step();
    bus2.HSEL   = 1'b0;
    bus2.HTRANS = 2'b00;
    bus2.HWDATA = wdata;
    while (bus2.HREADYOUT == 1'b0 && waits < 50) begin
      waits++;
      step();
    end
    if (waits >= 50) begin
      n_checks++;
      $display("FAIL ws2_timeout: got %0d stall cycles expected %0d", waits, exp_waits);
    end else begin
      chk("ws2_wait_cycles", 32'(waits), 32'(exp_waits));
      chk("ws2_hresp", 32'(bus2.HRESP), 32'd0);
      if (!wr) chk("ws2_hrdata", bus2.HRDATA, exp);
      step();
    end
  endtask

  initial begin
    bus0.HSEL = 1'b0; bus0.HADDR = '0; bus0.HTRANS = 2'b00; bus0.HWRITE = 1'b0;
    bus0.HSIZE = 3'd0; bus0.HREADY = 1'b1; bus0.HWDATA = '0;
    bus2.HSEL = 1'b0; bus2.HADDR = '0; bus2.HTRANS = 2'b00; bus2.HWRITE = 1'b0;
    bus2.HSIZE = 3'd0; bus2.HREADY = 1'b1; bus2.HWDATA = '0;

    //          wr    size  addr          wdata         err   expected read
    vecs.push_back('{1'b1, 3'd2, 32'h0000_0100, 32'hDEAD_BEEF, 1'b0, 32'h0});
    vecs.push_back('{1'b0, 3'd2, 32'h0000_0100, 32'h0,         1'b0, 32'hDEAD_BEEF});
    vecs.push_back('{1'b1, 3'd2, 32'h0000_0100, 32'h1122_3344, 1'b0, 32'h0});
    vecs.push_back('{1'b1, 3'd0, 32'h0000_0101, 32'h0000_AA00, 1'b0, 32'h0});
    vecs.push_back('{1'b0, 3'd2, 32'h0000_0100, 32'h0,         1'b0, 32'h1122_AA44});
    vecs.push_back('{1'b1, 3'd1, 32'h0000_0102, 32'h5566_0000, 1'b0, 32'h0});
    vecs.push_back('{1'b0, 3'd2, 32'h0000_0100, 32'h0,         1'b0, 32'h5566_AA44});
    vecs.push_back('{1'b0, 3'd2, 32'hFFFF_C100, 32'h0,         1'b0, 32'h5566_AA44});
    vecs.push_back('{1'b1, 3'd0, 32'h0000_0103, 32'h7700_0000, 1'b0, 32'h0});
    vecs.push_back('{1'b0, 3'd0, 32'h0000_0101, 32'h0,         1'b0, 32'h7766_AA44});
    vecs.push_back('{1'b1, 3'd2, 32'h0000_0200, 32'hA5A5_A5A5, 1'b0, 32'h0});
    vecs.push_back('{1'b0, 3'd1, 32'h0000_0203, 32'h0,         1'b1, 32'h0});
    vecs.push_back('{1'b1, 3'd1, 32'h0000_0203, 32'hFFFF_FFFF, 1'b1, 32'h0});
    vecs.push_back('{1'b0, 3'd3, 32'h0000_0200, 32'h0,         1'b1, 32'h0});
    vecs.push_back('{1'b1, 3'd2, 32'h0000_0202, 32'h0000_0000, 1'b1, 32'h0});
    vecs.push_back('{1'b0, 3'd0, 32'h0000_0203, 32'h0,         1'b0, 32'hA5A5_A5A5});
    vecs.push_back('{1'b1, 3'd2, 32'h0000_3FFC, 32'h600D_CAFE, 1'b0, 32'h0});
    vecs.push_back('{1'b0, 3'd2, 32'h0000_3FFC, 32'h0,         1'b0, 32'h600D_CAFE});

    rst0 = 1'b1;
    rst2 = 1'b1;
    step();
    step();
    rst0 = 1'b0;
    rst2 = 1'b0;
    chk("reset_hreadyout", 32'(bus0.HREADYOUT), 32'd1);
    chk("reset_hresp",     32'(bus0.HRESP),     32'd0);
    chk("reset_hrdata",    bus0.HRDATA,         32'h0);

    foreach (vecs[i]) run_vec0(vecs[i]);

    // IDLE and BUSY transfers while selected: zero-wait OKAY
    bus0.HSEL = 1'b1; bus0.HTRANS = 2'b00; bus0.HADDR = 32'h0000_0203; bus0.HSIZE = 3'd1;
    step();
    chk("idle_hreadyout", 32'(bus0.HREADYOUT), 32'd1);
    chk("idle_hresp",     32'(bus0.HRESP),     32'd0);
    bus0.HTRANS = 2'b01;
    step();
    chk("busy_hreadyout", 32'(bus0.HREADYOUT), 32'd1);
    chk("busy_hresp",     32'(bus0.HRESP),     32'd0);

    // Store then load of the same word accepted in the store's data phase
    bus0.HSEL = 1'b1; bus0.HTRANS = 2'b10; bus0.HWRITE = 1'b1; bus0.HSIZE = 3'd2;
    bus0.HADDR = 32'h0000_0200;
    step();
    bus0.HWDATA = 32'h0F0F_0F0F;
    bus0.HWRITE = 1'b0;
    chk("store_phase_hrdata", bus0.HRDATA, 32'h0);
    step();
    bus0.HSEL = 1'b0; bus0.HTRANS = 2'b00;
    chk("bypass_hreadyout", 32'(bus0.HREADYOUT), 32'd1);
    chk("bypass_hrdata",    bus0.HRDATA,         32'h0F0F_0F0F);
    step();
    chk("after_bypass_hrdata", bus0.HRDATA, 32'h0);

    // Two wait states on every OKAY transfer
    xfer2(1'b1, 32'h0000_0040, 32'h1357_9BDF, 32'h0, 2);
    xfer2(1'b0, 32'h0000_0040, 32'h0,         32'h1357_9BDF, 2);

    // HREADY low blocks acceptance even with HSEL high
    bus2.HSEL = 1'b1; bus2.HTRANS = 2'b10; bus2.HWRITE = 1'b0; bus2.HSIZE = 3'd2;
    bus2.HADDR = 32'h0000_0040; bus2.HREADY = 1'b0;
    step();
    bus2.HSEL = 1'b0; bus2.HTRANS = 2'b00; bus2.HREADY = 1'b1;
    chk("hready_block_hreadyout", 32'(bus2.HREADYOUT), 32'd1);
    step();
    chk("hready_block_stays_idle", 32'(bus2.HREADYOUT), 32'd1);

    // Reset during the WAIT of a store aborts it
    xfer2(1'b1, 32'h0000_0300, 32'h1111_1111, 32'h0, 2);
    bus2.HSEL = 1'b1; bus2.HTRANS = 2'b10; bus2.HWRITE = 1'b1; bus2.HSIZE = 3'd2;
    bus2.HADDR = 32'h0000_0300;
    step();
    bus2.HSEL = 1'b0; bus2.HTRANS = 2'b00; bus2.HWDATA = 32'h2222_2222;
    chk("wait_before_reset", 32'(bus2.HREADYOUT), 32'd0);
    rst2 = 1'b1;
    step();
    rst2 = 1'b0;
    chk("abort_hreadyout", 32'(bus2.HREADYOUT), 32'd1);
    chk("abort_hresp",     32'(bus2.HRESP),     32'd0);
    chk("abort_hrdata",    bus2.HRDATA,         32'h0);
    step();
    xfer2(1'b0, 32'h0000_0300, 32'h0, 32'h1111_1111, 2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
